// File: rtl/dds_control_arbiter.sv
// -----------------------------------------------------------------------------
// dds_control_pkg + dds_control_arbiter
//
// Purpose: merges two DDS control request streams (A = dwell controller,
// B = host) into the single registered Control_data write port of
// channelized_dds. It also runs a clear-all sequence that writes a "none"
// control word to every channel in turn.
//
// Ports:
//   Clk, Rst_n                   clock (rising edge), async active-low reset
//   Req_a_data / Req_a_ready     requester A request and accept strobe
//   Req_b_data / Req_b_ready     requester B request and accept strobe
//   Clear_req                    one-cycle pulse that starts the clear-all
//   Clear_busy                   high while the clear sequence runs; this is a
//                                direct decode of the FSM state register, so
//                                it doubles as the state debug view
//   Drop_error                   one-cycle pulse when an out-of-range request
//                                was consumed without a write
//   Control_data                 registered write toward channelized_dds
//
// Optional feature (macro DDS_CONTROL_ARBITER_STATS_EN):
//   Grant_count_a, Grant_count_b, Drop_count -- 32-bit saturating counters.
//   A "grant" is any accepted request (ready=1), including one that is then
//   dropped for an out-of-range channel.
//
// Handshake: a requester presents its word with .valid=1 and holds it,
// unchanged, until it sees its ready high in the same cycle. A transfer
// happens on the rising edge where valid and ready are both 1. Ready is
// combinational and never depends on the requester's own ready. An accepted
// in-range word appears on Control_data (with .valid=1) one edge later.
// -----------------------------------------------------------------------------
package dds_control_pkg;

  localparam int CH_FIELD_W = 8;

  typedef enum logic [1:0] {
    dds_control_type_none        = 2'd0,
    dds_control_type_single_tone = 2'd1,
    dds_control_type_sin_sweep   = 2'd2,
    dds_control_type_lin_sweep   = 2'd3
  } dds_control_type_t;

  typedef struct packed {
    logic [31:0] ftw;
    logic [31:0] step;
  } dds_setup_t;

  typedef struct packed {
    logic                  valid;
    logic [CH_FIELD_W-1:0] channel_index;
    dds_control_type_t     control_type;
    dds_setup_t            setup_data;
    logic [31:0]           control_data;
  } dds_control_t;

endpackage

module dds_control_arbiter
  import dds_control_pkg::*;
#(
  parameter int NUM_CHANNELS        = 16,
  parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS)
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  dds_control_t Req_a_data,
  output logic         Req_a_ready,
  input  dds_control_t Req_b_data,
  output logic         Req_b_ready,
  input  logic         Clear_req,
  output logic         Clear_busy,
  output logic         Drop_error,
  output dds_control_t Control_data
`ifdef DDS_CONTROL_ARBITER_STATS_EN
  ,
  output logic [31:0]  Grant_count_a,
  output logic [31:0]  Grant_count_b,
  output logic [31:0]  Drop_count
`endif
);

  // One spare bit so the clear counter can reach NUM_CHANNELS, which marks
  // the cycle that shows the final clear write and hands back to ARB.
  localparam int CNT_W = CHANNEL_INDEX_WIDTH + 1;
  localparam logic [CNT_W-1:0] CLR_DONE = CNT_W'(NUM_CHANNELS);
  localparam logic [CH_FIELD_W:0] NUM_CH_L = (CH_FIELD_W + 1)'(NUM_CHANNELS);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             last_b_q, last_b_d;   // 1: B was granted most recently
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  dds_control_t     control_q, control_d;
  logic             drop_q, drop_d;

  logic             grant_a;
  logic             grant_b;
  dds_control_t     sel_req;

  function automatic dds_control_t clear_write(input logic [CNT_W-1:0] idx);
    dds_control_t w;
    w               = '0;
    w.valid         = 1'b1;
    w.channel_index = CH_FIELD_W'(idx);
    w.control_type  = dds_control_type_none;
    return w;
  endfunction

  always_comb begin
    state_d         = state_q;
    last_b_d        = last_b_q;
    clr_cnt_d       = clr_cnt_q;
    control_d       = control_q;
    control_d.valid = 1'b0;        // fields hold, valid only for one cycle
    drop_d          = 1'b0;
    grant_a         = 1'b0;
    grant_b         = 1'b0;
    sel_req         = Req_a_data;

    case (state_q)
      ST_ARB: begin
        if (Clear_req) begin
          // Clear wins over pending requests; the first clear write is
          // launched right away so channel 0 shows in the first busy cycle.
          state_d   = ST_CLEAR;
          control_d = clear_write('0);
          clr_cnt_d = CNT_W'(1);
        end else begin
          if (Req_a_data.valid && (!Req_b_data.valid || last_b_q)) begin
            grant_a = 1'b1;
          end else if (Req_b_data.valid) begin
            grant_b = 1'b1;
          end

          if (grant_b) begin
            sel_req = Req_b_data;
          end

          if (grant_a || grant_b) begin
            last_b_d = grant_b;
            if ({1'b0, sel_req.channel_index} < NUM_CH_L) begin
              control_d       = sel_req;
              control_d.valid = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
        end
      end

      ST_CLEAR: begin
        // Clear_req is deliberately not looked at here.
        if (clr_cnt_q == CLR_DONE) begin
          state_d   = ST_ARB;
          clr_cnt_d = '0;
        end else begin
          control_d = clear_write(clr_cnt_q);
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_ARB;
        clr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_ARB;
      last_b_q  <= 1'b1;           // A wins the first tie after reset
      clr_cnt_q <= '0;
      control_q <= '0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_b_q  <= last_b_d;
      clr_cnt_q <= clr_cnt_d;
      control_q <= control_d;
      drop_q    <= drop_d;
    end
  end

  // Readies are gated by reset so nothing is accepted while Rst_n is low.
  assign Req_a_ready  = grant_a & Rst_n;
  assign Req_b_ready  = grant_b & Rst_n;
  assign Clear_busy   = (state_q == ST_CLEAR);
  assign Drop_error   = drop_q;
  assign Control_data = control_q;

`ifdef DDS_CONTROL_ARBITER_STATS_EN
  logic [31:0] grant_cnt_a_q, grant_cnt_a_d;
  logic [31:0] grant_cnt_b_q, grant_cnt_b_d;
  logic [31:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    grant_cnt_a_d = grant_cnt_a_q;
    grant_cnt_b_d = grant_cnt_b_q;
    drop_cnt_d    = drop_cnt_q;
    if (grant_a && (grant_cnt_a_q != 32'hFFFF_FFFF)) begin
      grant_cnt_a_d = grant_cnt_a_q + 32'd1;
    end
    if (grant_b && (grant_cnt_b_q != 32'hFFFF_FFFF)) begin
      grant_cnt_b_d = grant_cnt_b_q + 32'd1;
    end
    if (drop_d && (drop_cnt_q != 32'hFFFF_FFFF)) begin
      drop_cnt_d = drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      grant_cnt_a_q <= '0;
      grant_cnt_b_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      grant_cnt_a_q <= grant_cnt_a_d;
      grant_cnt_b_q <= grant_cnt_b_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign Grant_count_a = grant_cnt_a_q;
  assign Grant_count_b = grant_cnt_b_q;
  assign Drop_count    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dds_control_arbiter.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for dds_control_arbiter.
// u_dut   : default build, NUM_CHANNELS=16.
// u_dut12 : NUM_CHANNELS=12, CHANNEL_INDEX_WIDTH=5, for the range check.
// Inputs change 1 ns after a rising edge; the combinational readies are
// checked 1 ns later, and registered outputs 1 ns after the next edge.
// -----------------------------------------------------------------------------
module tb_dds_control_arbiter;
  import dds_control_pkg::*;

  logic         Clk;
  logic         Rst_n;
  dds_control_t req_a, req_b, req12;
  logic         a_ready, b_ready, clear_req, clear_busy, drop_error;
  dds_control_t control;
  logic         ready12_a, ready12_b, busy12, drop12;
  dds_control_t control12;
  dds_control_t idle_req;

`ifdef DDS_CONTROL_ARBITER_STATS_EN
  logic [31:0] cnt_a, cnt_b, cnt_drop;
  logic [31:0] cnt12_a, cnt12_b, cnt12_drop;
`endif

  int n_cmp;
  int n_err;

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  dds_control_arbiter u_dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req_a_data   (req_a),
    .Req_a_ready  (a_ready),
    .Req_b_data   (req_b),
    .Req_b_ready  (b_ready),
    .Clear_req    (clear_req),
    .Clear_busy   (clear_busy),
    .Drop_error   (drop_error),
    .Control_data (control)
`ifdef DDS_CONTROL_ARBITER_STATS_EN
    ,
    .Grant_count_a(cnt_a),
    .Grant_count_b(cnt_b),
    .Drop_count   (cnt_drop)
`endif
  );

  dds_control_arbiter #(
    .NUM_CHANNELS       (12),
    .CHANNEL_INDEX_WIDTH(5)
  ) u_dut12 (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Req_a_data   (req12),
    .Req_a_ready  (ready12_a),
    .Req_b_data   (idle_req),
    .Req_b_ready  (ready12_b),
    .Clear_req    (1'b0),
    .Clear_busy   (busy12),
    .Drop_error   (drop12),
    .Control_data (control12)
`ifdef DDS_CONTROL_ARBITER_STATS_EN
    ,
    .Grant_count_a(cnt12_a),
    .Grant_count_b(cnt12_b),
    .Drop_count   (cnt12_drop)
`endif
  );

  // ---------------- helpers ----------------
  function automatic dds_control_t mk(input logic v, input logic [7:0] ch,
                                      input dds_control_type_t t,
                                      input logic [31:0] ftw,
                                      input logic [31:0] stp,
                                      input logic [31:0] cd);
    dds_control_t r;
    r.valid            = v;
    r.channel_index    = ch;
    r.control_type     = t;
    r.setup_data.ftw   = ftw;
    r.setup_data.step  = stp;
    r.control_data     = cd;
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic go_idle();
    req_a     = idle_req;
    req_b     = idle_req;
    req12     = idle_req;
    clear_req = 1'b0;
  endtask

  task automatic do_reset();
    go_idle();
    Rst_n = 1'b0;
    step();
    Rst_n = 1'b1;
    step();
  endtask

  // One request into u_dut (A side): ready same cycle, then write or drop.
  task automatic single_a(input string tag, input logic [7:0] ch,
                          input logic exp_drop);
    dds_control_t r;
    r     = mk(1'b1, ch, dds_control_type_single_tone, 32'h10 + 32'(ch), 32'h1, 32'(ch));
    req_a = r;
    #1;
    check({tag, "_ready"}, 128'(a_ready), 128'(1'b1));
    step();
    req_a = idle_req;
    check({tag, "_wvalid"}, 128'(control.valid), 128'(!exp_drop));
    if (!exp_drop) check({tag, "_write"}, 128'(control), 128'(r));
    check({tag, "_drop"}, 128'(drop_error), 128'(exp_drop));
    step();
    check({tag, "_drop_end"}, 128'(drop_error), 128'(1'b0));
  endtask

  task automatic single_12(input string tag, input logic [7:0] ch,
                           input logic exp_drop);
    dds_control_t r;
    r     = mk(1'b1, ch, dds_control_type_lin_sweep, 32'h20, 32'h2, 32'(ch));
    req12 = r;
    #1;
    check({tag, "_ready"}, 128'(ready12_a), 128'(1'b1));
    step();
    req12 = idle_req;
    check({tag, "_wvalid"}, 128'(control12.valid), 128'(!exp_drop));
    if (!exp_drop) check({tag, "_write"}, 128'(control12), 128'(r));
    check({tag, "_drop"}, 128'(drop12), 128'(exp_drop));
    step();
    check({tag, "_drop_end"}, 128'(drop12), 128'(1'b0));
  endtask

  // ---------------- stimulus + checks ----------------
  initial begin
    dds_control_t pa, exp_w;
    logic [5:0]   exp_is_b;
    int           seq_a, seq_b;

    n_cmp    = 0;
    n_err    = 0;
    idle_req = '0;
    go_idle();
    Rst_n    = 1'b0;

    // Reset state, with a request already valid.
    req_a = mk(1'b1, 8'd3, dds_control_type_sin_sweep, 32'h1, 32'h2, 32'h3);
    #3;
    check("rst_a_ready", 128'(a_ready), 128'(1'b0));
    check("rst_control", 128'(control), 128'(0));
    check("rst_busy", 128'(clear_busy), 128'(1'b0));
    check("rst_drop", 128'(drop_error), 128'(1'b0));
    go_idle();
    repeat (2) @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // Single A request, channel 3, sin_sweep.
    pa    = mk(1'b1, 8'd3, dds_control_type_sin_sweep, 32'h1111, 32'h22, 32'h33);
    req_a = pa;
    #1;
    check("t1_a_ready", 128'(a_ready), 128'(1'b1));
    check("t1_b_ready", 128'(b_ready), 128'(1'b0));
    step();
    req_a = idle_req;
    check("t1_write", 128'(control), 128'(pa));
    step();
    exp_w       = pa;
    exp_w.valid = 1'b0;
    check("t1_hold", 128'(control), 128'(exp_w));

    // Both requesters valid for 6 cycles after reset: A,B,A,B,A,B.
    do_reset();
    exp_is_b = 6'b101010;
    seq_a    = 0;
    seq_b    = 0;
    for (int i = 0; i < 6; i++) begin
      req_a = mk(1'b1, 8'd1, dds_control_type_single_tone, 32'h0, 32'h0, 32'(100 + seq_a));
      req_b = mk(1'b1, 8'd2, dds_control_type_lin_sweep, 32'h0, 32'h0, 32'(200 + seq_b));
      #1;
      check($sformatf("rr%0d_a_ready", i), 128'(a_ready), 128'(!exp_is_b[i]));
      check($sformatf("rr%0d_b_ready", i), 128'(b_ready), 128'(exp_is_b[i]));
      exp_w = exp_is_b[i] ? req_b : req_a;
      step();
      check($sformatf("rr%0d_write", i), 128'(control), 128'(exp_w));
      if (exp_is_b[i]) seq_b++;
      else seq_a++;
    end
    go_idle();

    // Clear with A valid in the same cycle; a second Clear_req mid-sequence.
    pa        = mk(1'b1, 8'd4, dds_control_type_single_tone, 32'h5, 32'h6, 32'h7);
    req_a     = pa;
    clear_req = 1'b1;
    #1;
    check("clr_a_ready0", 128'(a_ready), 128'(1'b0));
    check("clr_busy0", 128'(clear_busy), 128'(1'b0));
    step();
    for (int k = 0; k < 16; k++) begin
      clear_req = (k == 3);
      #1;
      check($sformatf("clr%0d_busy", k), 128'(clear_busy), 128'(1'b1));
      check($sformatf("clr%0d_a_ready", k), 128'(a_ready), 128'(1'b0));
      check($sformatf("clr%0d_write", k), 128'(control),
            128'(mk(1'b1, 8'(k), dds_control_type_none, 32'h0, 32'h0, 32'h0)));
      step();
    end
    clear_req = 1'b0;
    #1;
    check("clr_end_busy", 128'(clear_busy), 128'(1'b0));
    check("clr_end_a_ready", 128'(a_ready), 128'(1'b1));
    check("clr_end_nowrite", 128'(control),
          128'(mk(1'b0, 8'd15, dds_control_type_none, 32'h0, 32'h0, 32'h0)));
    step();
    req_a = idle_req;
    check("clr_end_a_write", 128'(control), 128'(pa));
    step();

    // Channel range boundaries, 16 channels then 12 channels.
    single_a("rng15", 8'd15, 1'b0);
    single_a("rng16", 8'd16, 1'b1);
    single_a("rng20", 8'd20, 1'b1);
    single_12("n12_ch11", 8'd11, 1'b0);
    single_12("n12_ch12", 8'd12, 1'b1);
    single_12("n12_ch20", 8'd20, 1'b1);

    // Reset while clear write 5 is on the output.
    do_reset();
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("abort_w%0d", k), 128'(control),
            128'(mk(1'b1, 8'(k), dds_control_type_none, 32'h0, 32'h0, 32'h0)));
      if (k < 5) step();
    end
    req_a = mk(1'b1, 8'd9, dds_control_type_sin_sweep, 32'h1, 32'h1, 32'h1);
    Rst_n = 1'b0;
    #1;
    check("abort_control0", 128'(control), 128'(0));
    check("abort_busy0", 128'(clear_busy), 128'(1'b0));
    check("abort_ready0", 128'(a_ready), 128'(1'b0));
    req_a = idle_req;
    step();
    Rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check($sformatf("abort_quiet%0d", k), 128'(control.valid), 128'(1'b0));
    end
    check("abort_busy_after", 128'(clear_busy), 128'(1'b0));
    pa    = mk(1'b1, 8'd7, dds_control_type_sin_sweep, 32'hABCD, 32'h12, 32'h99);
    req_a = pa;
    #1;
    check("abort_next_ready", 128'(a_ready), 128'(1'b1));
    step();
    req_a = idle_req;
    check("abort_next_write", 128'(control), 128'(pa));

`ifdef DDS_CONTROL_ARBITER_STATS_EN
    // 9 good A + 1 dropped A = 10 A grants, 7 B grants, 1 drop.
    do_reset();
    check("stat_rst_a", 128'(cnt_a), 128'(0));
    for (int i = 0; i < 9; i++) begin
      req_a = mk(1'b1, 8'(i), dds_control_type_single_tone, 32'h0, 32'h0, 32'(i));
      step();
    end
    req_a = mk(1'b1, 8'd30, dds_control_type_single_tone, 32'h0, 32'h0, 32'h0);
    step();
    req_a = idle_req;
    for (int i = 0; i < 7; i++) begin
      req_b = mk(1'b1, 8'(i), dds_control_type_lin_sweep, 32'h0, 32'h0, 32'(i));
      step();
    end
    go_idle();
    step();
    check("stat_grant_a", 128'(cnt_a), 128'(32'd10));
    check("stat_grant_b", 128'(cnt_b), 128'(32'd7));
    check("stat_drop", 128'(cnt_drop), 128'(32'd1));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
